// File: rtl/keccak_pkg.sv
// Shared Keccak/SHAKE definitions: lane width, rates, mode encodings,
// the squeeze-store state type and the byte-order helper.
package keccak_pkg;

  localparam int unsigned w             = 64;
  localparam int unsigned RATE_SHAKE128 = 1344;
  localparam int unsigned RATE_SHAKE256 = 1088;

  localparam logic [1:0] SHA3_256_MODE_VEC = 2'b00;
  localparam logic [1:0] SHA3_512_MODE_VEC = 2'b01;
  localparam logic [1:0] SHAKE128_MODE_VEC = 2'b10;
  localparam logic [1:0] SHAKE256_MODE_VEC = 2'b11;

  // Output words per squeezed block (rate / w)
  localparam logic [4:0] WORDS_SHAKE128 = 5'd21;
  localparam logic [4:0] WORDS_SHAKE256 = 5'd17;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BLOCK,
    DRAIN,
    FINISH
  } store_state_t;

  // Reverse the byte order of one lane
  function automatic logic [w-1:0] EndianSwitcher(input logic [w-1:0] x);
    logic [w-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < w / 8; i++) begin
      r[8*i +: 8] = x[w-8-8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/squeeze_store_stage_piso_buffer.sv
// Parallel-in serial-out lane buffer: loads a whole rate block at once and
// shifts it out one WIDTH-bit lane at a time, lane 0 first.
module piso_buffer #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 21
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_i,
  input  logic                   shift_i,
  input  logic [WIDTH*DEPTH-1:0] data_i,
  output logic [WIDTH-1:0]       word_o
);

  logic [WIDTH*DEPTH-1:0] sreg_q;
  logic [WIDTH*DEPTH-1:0] sreg_d;

  // Next buffer contents: load has priority over shift, vacated lanes fill with zero
  always_comb begin
    sreg_d = sreg_q;
    if (load_i) begin
      sreg_d = data_i;
    end else if (shift_i) begin
      sreg_d = {{WIDTH{1'b0}}, sreg_q[WIDTH*DEPTH-1:WIDTH]};
    end
  end

  // Buffer register with synchronous active-low clear
  always_ff @(posedge clk) begin
    if (!rst) begin
      sreg_q <= '0;
    end else begin
      sreg_q <= sreg_d;
    end
  end

  assign word_o = sreg_q[WIDTH-1:0];

endmodule

// File: rtl/squeeze_store_stage.sv
// Final SHAKE pipeline stage: takes squeezed rate blocks, serialises them into
// byte-swapped W-bit words on a valid/ready stream, counts down the requested
// output length and pulses done_o after the last word.
// Optional: define STORE_BYTE_STROBE_EN to add a per-byte keep_o strobe.
module squeeze_store_stage
  import keccak_pkg::*;
#(
  parameter int unsigned W        = 64,
  parameter int unsigned RATE_MAX = 1344
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic [1:0]          mode_i,
  input  logic [31:0]         output_size_i,
  input  logic                block_valid_i,
  output logic                block_ready_o,
  input  logic [RATE_MAX-1:0] rate_i,
  output logic                squeeze_req_o,
  output logic [W-1:0]        data_o,
  output logic                valid_o,
  input  logic                ready_i,
  output logic                last_o,
  output logic                busy_o,
`ifdef STORE_BYTE_STROBE_EN
  output logic [W/8-1:0]      keep_o,
`endif
  output logic                done_o
);

  localparam int unsigned DEPTH = RATE_MAX / W;

  store_state_t state_q, state_d;
  logic [1:0]   mode_q, mode_d;
  logic [31:0]  rem_q, rem_d;
  logic [4:0]   idx_q, idx_d;

  logic         piso_load;
  logic         piso_shift;
  logic [W-1:0] piso_word;
  logic [4:0]   depth;
  logic         word_last;
  logic [W/8-1:0] byte_keep;
  logic [W-1:0]   byte_mask;

  piso_buffer #(
    .WIDTH (W),
    .DEPTH (DEPTH)
  ) u_piso (
    .clk     (clk),
    .rst     (rst),
    .load_i  (piso_load),
    .shift_i (piso_shift),
    .data_i  (rate_i),
    .word_o  (piso_word)
  );

  assign depth     = (mode_q == SHAKE256_MODE_VEC) ? WORDS_SHAKE256 : WORDS_SHAKE128;
  assign word_last = (rem_q <= 32'(W));

  // Byte strobe of the current word: byte i is valid when more than i bytes remain
  always_comb begin
    byte_keep = '0;
    byte_mask = '0;
    for (int unsigned i = 0; i < W / 8; i++) begin
      byte_keep[i]         = (rem_q >= 32'((i + 1) * 8));
      byte_mask[8*i +: 8]  = {8{byte_keep[i]}};
    end
  end

  // Output word: swapped lane with unused trailing bytes forced to zero
  always_comb begin
    data_o = '0;
    if (state_q == DRAIN) begin
      data_o = EndianSwitcher(piso_word) & byte_mask;
    end
  end

`ifdef STORE_BYTE_STROBE_EN
  // Strobe is only meaningful while a word is presented
  always_comb begin
    keep_o = '0;
    if (state_q == DRAIN) begin
      keep_o = byte_keep;
    end
  end
`endif

  // Next-state, counter updates and handshake outputs
  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    rem_d         = rem_q;
    idx_d         = idx_q;
    piso_load     = 1'b0;
    piso_shift    = 1'b0;
    block_ready_o = 1'b0;
    squeeze_req_o = 1'b0;
    valid_o       = 1'b0;
    last_o        = 1'b0;
    done_o        = 1'b0;
    busy_o        = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (start_i) begin
          mode_d  = mode_i;
          rem_d   = output_size_i;
          idx_d   = '0;
          state_d = (output_size_i == '0) ? FINISH : WAIT_BLOCK;
        end
      end
      WAIT_BLOCK: begin
        block_ready_o = 1'b1;
        squeeze_req_o = 1'b1;
        if (block_valid_i) begin
          piso_load = 1'b1;
          idx_d     = '0;
          state_d   = DRAIN;
        end
      end
      DRAIN: begin
        valid_o = 1'b1;
        last_o  = word_last;
        if (ready_i) begin
          piso_shift = 1'b1;
          idx_d      = idx_q + 5'd1;
          rem_d      = (rem_q > 32'(W)) ? (rem_q - 32'(W)) : '0;
          // Job end wins over block boundary, so an exact multiple never re-requests
          if (word_last) begin
            state_d = FINISH;
          end else if (idx_q == depth - 5'd1) begin
            state_d = WAIT_BLOCK;
          end
        end
      end
      FINISH: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and counter registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      mode_q  <= '0;
      rem_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: tb/tb_squeeze_store_stage.sv
// Scoreboard bench for squeeze_store_stage: jobs push expected words into a
// queue, a negedge monitor pops and compares every transferred word.
module tb_squeeze_store_stage;
  import keccak_pkg::*;

  localparam int unsigned W        = 64;
  localparam int unsigned RATE_MAX = 1344;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
    logic [7:0]  keep;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                start_i = 1'b0;
  logic [1:0]          mode_i = 2'b00;
  logic [31:0]         output_size_i = '0;
  logic                block_valid_i = 1'b0;
  logic                block_ready_o;
  logic [RATE_MAX-1:0] rate_i = '0;
  logic                squeeze_req_o;
  logic [W-1:0]        data_o;
  logic                valid_o;
  logic                ready_i = 1'b1;
  logic                last_o;
  logic                busy_o;
  logic                done_o;
`ifdef STORE_BYTE_STROBE_EN
  logic [W/8-1:0]      keep_o;
`endif

  squeeze_store_stage #(
    .W        (W),
    .RATE_MAX (RATE_MAX)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .mode_i        (mode_i),
    .output_size_i (output_size_i),
    .block_valid_i (block_valid_i),
    .block_ready_o (block_ready_o),
    .rate_i        (rate_i),
    .squeeze_req_o (squeeze_req_o),
    .data_o        (data_o),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .last_o        (last_o),
    .busy_o        (busy_o),
`ifdef STORE_BYTE_STROBE_EN
    .keep_o        (keep_o),
`endif
    .done_o        (done_o)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int n_checks = 0;
  int n_fail   = 0;

  int cyc = 0, hs_count = 0, req_rises = 0, bready_seen = 0, valid_seen = 0;
  int words_seen = 0, done_count = 0, hs_cyc = 0, last_cyc = 0, done_cyc = 0;
  int blk_n = 0, bp_cnt = 0;
  bit hs_pend = 0, have_last = 0, bp_mode = 0;
  logic prev_req = 1'b0, prev_valid = 1'b0, stall_prev = 1'b0, stall_last = 1'b0;
  logic [63:0] stall_data = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] lane_val(input int b, input int j);
    return {8'(b), 8'(j), 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'(j * 7 + b * 3 + 1)};
  endfunction

  function automatic logic [RATE_MAX-1:0] make_block(input int b);
    logic [RATE_MAX-1:0] r;
    r = '0;
    for (int j = 0; j < 21; j++) r[j*64 +: 64] = lane_val(b, j);
    return r;
  endfunction

  function automatic logic [63:0] bswap(input logic [63:0] x);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[56 - 8*i +: 8] = x[8*i +: 8];
    return r;
  endfunction

  // Monitor: counts events and compares transferred words against the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (block_valid_i && block_ready_o) begin
        hs_count++;
        hs_pend = 1;
        hs_cyc  = cyc;
      end
      if (squeeze_req_o && !prev_req) req_rises++;
      prev_req = squeeze_req_o;
      if (block_ready_o) bready_seen++;
      if (valid_o) valid_seen++;
      if (valid_o && !prev_valid) check("first_word_latency", 64'(cyc - hs_cyc), 64'd1);
      prev_valid = valid_o;
      if (done_o) begin
        done_count++;
        done_cyc = cyc;
        if (have_last) begin
          check("done_after_last", 64'(cyc - last_cyc), 64'd1);
          have_last = 0;
        end
      end
      if (stall_prev && valid_o) begin
        check("stall_data", data_o, stall_data);
        check("stall_last", 64'(last_o), 64'(stall_last));
      end
      if (valid_o && ready_i) begin
        words_seen++;
        check("sb_nonempty", 64'(q.size() > 0), 64'd1);
        if (q.size() > 0) begin
          e = q.pop_front();
          check("word_data", data_o, e.data);
          check("word_last", 64'(last_o), 64'(e.last));
`ifdef STORE_BYTE_STROBE_EN
          check("word_keep", 64'(keep_o), 64'(e.keep));
`endif
        end
        if (last_o) begin
          have_last = 1;
          last_cyc  = cyc;
        end
      end
      stall_prev = valid_o && !ready_i;
      stall_data = data_o;
      stall_last = last_o;
    end
  end

  // Block source and consumer: next block after each handshake, ready pattern 1,0,0,1
  initial begin
    logic [3:0] pat;
    pat = 4'b1001;
    rate_i = make_block(0);
    forever begin
      @(posedge clk);
      #1;
      if (hs_pend) begin
        blk_n++;
        rate_i  = make_block(blk_n);
        hs_pend = 0;
      end
      if (bp_mode) begin
        ready_i = pat[bp_cnt % 4];
        bp_cnt++;
      end else begin
        ready_i = 1'b1;
      end
    end
  end

  task automatic push_expected(input logic [1:0] mode, input int size);
    int depth, nwords, rem, k, b, j;
    exp_t e;
    depth  = (mode == SHAKE256_MODE_VEC) ? 17 : 21;
    nwords = (size + 63) / 64;
    for (int n = 0; n < nwords; n++) begin
      b   = blk_n + n / depth;
      j   = n % depth;
      rem = size - n * 64;
      k   = (rem >= 64) ? 8 : rem / 8;
      e.data = bswap(lane_val(b, j));
      e.keep = '0;
      for (int i = 0; i < 8; i++) begin
        if (i >= k) e.data[8*i +: 8] = 8'h00;
        else        e.keep[i] = 1'b1;
      end
      e.last = (n == nwords - 1);
      q.push_back(e);
    end
  endtask

  task automatic pulse_start(input logic [1:0] mode, input int size, output int sc);
    @(posedge clk);
    #1;
    mode_i        = mode;
    output_size_i = 32'(size);
    start_i       = 1'b1;
    sc            = cyc + 1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  task automatic run_job(input logic [1:0] mode, input int size, input bit bp);
    int depth, nwords, nblk, hs0, rq0, w0, d0, br0, v0, sc, t;
    depth  = (mode == SHAKE256_MODE_VEC) ? 17 : 21;
    nwords = (size + 63) / 64;
    nblk   = (nwords + depth - 1) / depth;
    hs0 = hs_count; rq0 = req_rises; w0 = words_seen;
    d0  = done_count; br0 = bready_seen; v0 = valid_seen;
    push_expected(mode, size);
    bp_mode = bp;
    pulse_start(mode, size, sc);
    t = 0;
    while (done_count == d0 && t < 3000) begin
      @(negedge clk);
      #1;
      t++;
    end
    repeat (4) @(negedge clk);
    #1;
    bp_mode = 0;
    check("done_pulses",   64'(done_count - d0), 64'd1);
    check("block_hs",      64'(hs_count - hs0), 64'(nblk));
    check("squeeze_reqs",  64'(req_rises - rq0), 64'(nblk));
    check("word_count",    64'(words_seen - w0), 64'(nwords));
    check("sb_drained",    64'(q.size()), 64'd0);
    check("idle_busy",     64'(busy_o), 64'd0);
    if (size == 0) begin
      check("zero_done_lat",  64'(done_cyc - sc), 64'd1);
      check("zero_no_bready", 64'(bready_seen - br0), 64'd0);
      check("zero_no_valid",  64'(valid_seen - v0), 64'd0);
    end
    q.delete();
  endtask

  initial begin
    int w0, t, sc;
    block_valid_i = 1'b1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid",  64'(valid_o), 64'd0);
    check("rst_busy",   64'(busy_o), 64'd0);
    check("rst_bready", 64'(block_ready_o), 64'd0);
    check("rst_req",    64'(squeeze_req_o), 64'd0);
    check("rst_done",   64'(done_o), 64'd0);
    check("rst_last",   64'(last_o), 64'd0);
    check("rst_data",   data_o, 64'd0);
`ifdef STORE_BYTE_STROBE_EN
    check("rst_keep",   64'(keep_o), 64'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b1;

    run_job(SHAKE128_MODE_VEC, 256, 0);
    run_job(SHAKE256_MODE_VEC, 1088 * 2 + 128, 0);
    run_job(SHAKE128_MODE_VEC, 200, 0);
    run_job(SHAKE128_MODE_VEC, 512, 1);
    run_job(SHAKE256_MODE_VEC, 1088, 0);
    run_job(SHAKE128_MODE_VEC, 1344, 0);
    run_job(SHAKE256_MODE_VEC, 0, 0);

    // Abort a job while word 5 is presented
    w0 = words_seen;
    push_expected(SHAKE128_MODE_VEC, 1000);
    pulse_start(SHAKE128_MODE_VEC, 1000, sc);
    t = 0;
    while (words_seen - w0 < 4 && t < 3000) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("abort_reached_w5", 64'(words_seen - w0), 64'd4);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_valid", 64'(valid_o), 64'd0);
    check("abort_busy",  64'(busy_o), 64'd0);
    check("abort_done",  64'(done_o), 64'd0);
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    run_job(SHAKE128_MODE_VEC, 256, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
